// File: rtl/c2c_store_buffer.sv
// c2c_store_buffer
//
// Posted-write buffer placed directly after the core's c2c_w slave port.
// Core writes are acknowledged in the same cycle while space remains, held
// in order in a small circular FIFO, and drained one at a time to the
// cache/memory-side write port.
//
// The downstream port uses a hold-until-ack strobe handshake. Occupancy is
// reported so the core can hold fences until every posted write has retired.
//
// Parameters
//   XLEN   address/data width, a multiple of 8
//   DEPTH  number of buffered writes, a power of two, >= 2
//
// Ports
//   clk, reset_n              single rising-edge clock, async active-low reset
//   c_we, c_sel, c_addr,      core write request (c2c_w.slave)
//   c_data
//   c_ack                     write accepted this cycle
//   m_stb                     downstream write request valid
//   m_sel, m_addr, m_data     head entry, stable while m_stb && !m_ack
//   m_ack                     downstream write complete
//   empty                     no writes pending
//   count                     buffered entries, including the head
module c2c_store_buffer #(
   parameter int XLEN  = 32,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     c_we,
   input  logic [XLEN/8-1:0]        c_sel,
   input  logic [XLEN-1:0]          c_addr,
   input  logic [XLEN-1:0]          c_data,
   output logic                     c_ack,
   output logic                     m_stb,
   output logic [XLEN/8-1:0]        m_sel,
   output logic [XLEN-1:0]          m_addr,
   output logic [XLEN-1:0]          m_data,
   input  logic                     m_ack,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam int SW = XLEN / 8;
   localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

   logic [SW-1:0]   sel_mem  [DEPTH];
   logic [XLEN-1:0] addr_mem [DEPTH];
   logic [XLEN-1:0] data_mem [DEPTH];

   logic [PW-1:0]   wr_ptr;
   logic [PW-1:0]   rd_ptr;
   logic [CW-1:0]   count_q;

   logic            push;
   logic            pop;

   // Acceptance depends only on c_we and registered occupancy. A pop in the
   // same cycle deliberately does not free a slot, so there is no m_ack to
   // c_ack combinational path.
   assign c_ack = c_we && (count_q != FULL_COUNT);

   // A zero byte-enable write is acknowledged but never stored.
   assign push  = c_ack && (c_sel != '0);
   assign pop   = m_stb && m_ack;

   assign m_stb  = (count_q != '0);
   assign empty  = (count_q == '0);
   assign count  = count_q;

   assign m_sel  = sel_mem[rd_ptr];
   assign m_addr = addr_mem[rd_ptr];
   assign m_data = data_mem[rd_ptr];

   // NOTE: storage carries no reset; occupancy alone decides which entries
   // are valid, so this block needs no reset branch.
   always_ff @(posedge clk) begin
      if (push) begin
         sel_mem[wr_ptr]  <= c_sel;
         addr_mem[wr_ptr] <= c_addr;
         data_mem[wr_ptr] <= c_data;
      end
   end

   // NOTE: non-blocking assignments let every register see pre-edge values,
   // which simultaneous push and pop depend on.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_q <= '0;
      end else begin
         // Pointers wrap naturally at DEPTH because DEPTH is a power of two.
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);
         case ({push, pop})
            2'b10:   count_q <= count_q + CW'(1);
            2'b01:   count_q <= count_q - CW'(1);
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

// File: tb/tb_c2c_store_buffer.sv
// Testbench for c2c_store_buffer. A queue-based reference model tracks which
// writes should be pending; every cycle the DUT outputs are compared with it.
module tb_c2c_store_buffer;

   localparam int XLEN  = 32;
   localparam int DEPTH = 4;

   typedef struct packed {
      logic [3:0]  sel;
      logic [31:0] addr;
      logic [31:0] data;
   } ent_t;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        c_we;
   logic [3:0]  c_sel;
   logic [31:0] c_addr;
   logic [31:0] c_data;
   logic        c_ack;
   logic        m_stb;
   logic [3:0]  m_sel;
   logic [31:0] m_addr;
   logic [31:0] m_data;
   logic        m_ack;
   logic        empty;
   logic [2:0]  count;

   int n_cmp = 0;
   int n_err = 0;

   ent_t        q[$];
   logic [31:0] drained[$];
   logic [31:0] expect_addrs[$];

   c2c_store_buffer #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
      .clk    (clk),
      .reset_n(reset_n),
      .c_we   (c_we),
      .c_sel  (c_sel),
      .c_addr (c_addr),
      .c_data (c_data),
      .c_ack  (c_ack),
      .m_stb  (m_stb),
      .m_sel  (m_sel),
      .m_addr (m_addr),
      .m_data (m_data),
      .m_ack  (m_ack),
      .empty  (empty),
      .count  (count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock cycle: drive inputs at the falling edge, compare outputs with
   // the model, then apply the model's update at the rising edge.
   task automatic step(input logic we, input logic [3:0] sel, input logic [31:0] addr,
                       input logic [31:0] data, input logic ack, output logic acked);
      logic exp_ack;
      logic exp_stb;
      ent_t e;
      c_we   = we;
      c_sel  = sel;
      c_addr = addr;
      c_data = data;
      m_ack  = ack;
      #1;
      exp_ack = we && (q.size() != DEPTH);
      exp_stb = (q.size() != 0);
      check("c_ack", 64'(c_ack), 64'(exp_ack));
      check("m_stb", 64'(m_stb), 64'(exp_stb));
      check("empty", 64'(empty), 64'(q.size() == 0));
      check("count", 64'(count), 64'(q.size()));
      if (exp_stb) begin
         check("m_sel",  64'(m_sel),  64'(q[0].sel));
         check("m_addr", 64'(m_addr), 64'(q[0].addr));
         check("m_data", 64'(m_data), 64'(q[0].data));
      end
      acked = exp_ack;
      @(posedge clk);
      if (exp_stb && ack) begin
         drained.push_back(q[0].addr);
         void'(q.pop_front());
      end
      if (exp_ack && sel != 4'h0) begin
         e.sel  = sel;
         e.addr = addr;
         e.data = data;
         q.push_back(e);
      end
      @(negedge clk);
   endtask

   task automatic check_drained(input string tag);
      check({tag, "_len"}, 64'(drained.size()), 64'(expect_addrs.size()));
      for (int i = 0; i < expect_addrs.size() && i < drained.size(); i++)
         check({tag, "_order"}, 64'(drained[i]), 64'(expect_addrs[i]));
   endtask

   initial begin
      logic acked;
      logic pend;
      ent_t r;

      reset_n = 1'b0;
      c_we    = 1'b0;
      c_sel   = 4'h0;
      c_addr  = '0;
      c_data  = '0;
      m_ack   = 1'b0;
      pend    = 1'b0;
      r       = '0;

      // Reset values.
      @(negedge clk);
      #1;
      check("rst_count", 64'(count), 64'd0);
      check("rst_m_stb", 64'(m_stb), 64'd0);
      check("rst_empty", 64'(empty), 64'd1);
      check("rst_c_ack", 64'(c_ack), 64'd0);
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);

      // Single write, then drain it.
      step(1'b1, 4'hF, 32'h1000, 32'hDEADBEEF, 1'b0, acked);
      step(1'b0, 4'h0, 32'h0, 32'h0, 1'b0, acked);
      step(1'b0, 4'h0, 32'h0, 32'h0, 1'b1, acked);
      step(1'b0, 4'h0, 32'h0, 32'h0, 1'b0, acked);

      // Fill to full; the fifth write is held until a pop frees a slot.
      drained.delete();
      expect_addrs = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10};
      for (int i = 0; i < 4; i++)
         step(1'b1, 4'hF, 32'(i * 4), 32'hA000 + 32'(i), 1'b0, acked);
      step(1'b1, 4'hF, 32'h10, 32'hA004, 1'b0, acked);
      check("fill_full_count", 64'(count), 64'd4);
      step(1'b1, 4'hF, 32'h10, 32'hA004, 1'b1, acked);
      check("fill_blocked_on_pop", 64'(acked), 64'd0);
      step(1'b1, 4'hF, 32'h10, 32'hA004, 1'b0, acked);
      check("fill_fifth_acked", 64'(acked), 64'd1);
      for (int i = 0; i < 5; i++)
         step(1'b0, 4'h0, 32'h0, 32'h0, 1'b1, acked);
      step(1'b0, 4'h0, 32'h0, 32'h0, 1'b0, acked);
      check_drained("fill");

      // Streaming with m_ack held high; pointers wrap more than once.
      drained.delete();
      expect_addrs.delete();
      for (int i = 0; i < 10; i++) begin
         expect_addrs.push_back(32'h2000 + 32'(i * 4));
         step(1'b1, 4'(i + 1), 32'h2000 + 32'(i * 4), $urandom, 1'b1, acked);
         check("stream_ack", 64'(acked), 64'd1);
         check("stream_count_le1", 64'(count <= 3'd1), 64'd1);
      end
      step(1'b0, 4'h0, 32'h0, 32'h0, 1'b1, acked);
      step(1'b0, 4'h0, 32'h0, 32'h0, 1'b0, acked);
      check_drained("stream");

      // Zero byte-enable write: acked, not stored.
      step(1'b1, 4'h0, 32'h3000, 32'h55AA55AA, 1'b0, acked);
      check("zero_sel_ack", 64'(acked), 64'd1);
      step(1'b0, 4'h0, 32'h0, 32'h0, 1'b0, acked);
      check("zero_sel_count", 64'(count), 64'd0);
      check("zero_sel_m_stb", 64'(m_stb), 64'd0);

      // Randomized traffic with the core holding each request until acked.
      for (int i = 0; i < 400; i++) begin
         if (!pend && $urandom_range(0, 3) != 0) begin
            pend   = 1'b1;
            r.sel  = ($urandom_range(0, 7) == 0) ? 4'h0 : 4'($urandom);
            r.addr = $urandom;
            r.data = $urandom;
         end
         step(pend, r.sel, r.addr, r.data, 1'($urandom_range(0, 2) == 0), acked);
         if (acked) pend = 1'b0;
      end
      for (int i = 0; i < DEPTH + 1; i++)
         step(1'b0, 4'h0, 32'h0, 32'h0, 1'b1, acked);

      // Reset mid-drain: three entries queued, downstream stalled.
      for (int i = 0; i < 3; i++)
         step(1'b1, 4'hF, 32'h4000 + 32'(i * 4), 32'hB000 + 32'(i), 1'b0, acked);
      c_we  = 1'b0;
      m_ack = 1'b0;
      #2;
      reset_n = 1'b0;
      #1;
      check("mid_rst_m_stb", 64'(m_stb), 64'd0);
      check("mid_rst_count", 64'(count), 64'd0);
      check("mid_rst_empty", 64'(empty), 64'd1);
      q.delete();
      @(negedge clk);
      reset_n = 1'b1;
      for (int i = 0; i < 3; i++)
         step(1'b0, 4'h0, 32'h0, 32'h0, 1'b1, acked);
      step(1'b1, 4'h3, 32'h5000, 32'h12345678, 1'b0, acked);
      step(1'b0, 4'h0, 32'h0, 32'h0, 1'b1, acked);
      step(1'b0, 4'h0, 32'h0, 32'h0, 1'b0, acked);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
